// File: rtl/tag_array_pkg.sv
// Shared types and sizes for the 2-way, 64-set tag array controller.
package tag_array_pkg;
  localparam int unsigned SETS  = 64;
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 23;
  localparam int unsigned WAY_W = 24;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/tag_array_ctrl_if.sv
// Request/response bundle between the cache pipeline (master) and the tag array controller (slave).
interface tag_array_ctrl_if;
  logic                           lk_valid;
  logic                           lk_ready;
  logic [tag_array_pkg::IDX_W-1:0] lk_idx;
  logic [tag_array_pkg::TAG_W-1:0] lk_tag;
  logic                           rsp_valid;
  logic                           rsp_hit;
  logic                           rsp_way;
  logic                           rsp_victim;
  logic                           fill_valid;
  logic                           fill_ready;
  logic [tag_array_pkg::IDX_W-1:0] fill_idx;
  logic                           fill_way;
  logic [tag_array_pkg::TAG_W-1:0] fill_tag;
  logic                           fill_vld;

  modport master (
    output lk_valid, lk_idx, lk_tag, fill_valid, fill_idx, fill_way, fill_tag, fill_vld,
    input  lk_ready, fill_ready, rsp_valid, rsp_hit, rsp_way, rsp_victim
  );

  modport slave (
    input  lk_valid, lk_idx, lk_tag, fill_valid, fill_idx, fill_way, fill_tag, fill_vld,
    output lk_ready, fill_ready, rsp_valid, rsp_hit, rsp_way, rsp_victim
  );
endinterface

// File: rtl/tag_array_ctrl_cmp.sv
// Combinational 2-way tag compare and replacement-way selection on one SRAM read word.
module tag_cmp_2way
  import tag_array_pkg::*;
(
  input  logic [2*WAY_W-1:0] dout,
  input  logic [TAG_W-1:0]   tag,
  input  logic               rr_bit,
  output logic               hit,
  output logic               way,
  output logic               victim
);
  tag_entry_t e0, e1;
  logic       hit0, hit1;

  assign e0 = dout[WAY_W-1:0];
  assign e1 = dout[2*WAY_W-1:WAY_W];

  always_comb begin
    hit0 = e0.valid && (e0.tag == tag);
    hit1 = e1.valid && (e1.tag == tag);
    hit  = hit0 || hit1;
    // Double hit is an illegal array state; way0 is reported.
    way  = !hit0 && hit1;
    if (!e0.valid)      victim = 1'b0;
    else if (!e1.valid) victim = 1'b1;
    else                victim = rr_bit;
  end
endmodule

// File: rtl/tag_array_ctrl.sv
// Tag SRAM sequencer: clears all sets after reset, then arbitrates fills and lookups onto the single RW port.
module tag_array_ctrl
  import tag_array_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  tag_array_ctrl_if.slave      bus,
  output logic                 init_done,
  output logic                 sram_csb0,
  output logic                 sram_web0_aL,
  output logic [1:0]           sram_wmask0,
  output logic [IDX_W-1:0]     sram_addr0,
  output logic [2*WAY_W-1:0]   sram_din0,
  input  logic [2*WAY_W-1:0]   sram_dout0
);
  state_e           state;
  logic [IDX_W-1:0] init_cnt;
  logic [SETS-1:0]  rr_bits;
  logic [2:0]       fill_streak;
  logic             pend_vld;
  logic [TAG_W-1:0] pend_tag;
  logic             pend_rr;
  logic             active, guard, fill_gnt, lk_gnt;
  logic             cmp_hit, cmp_way, cmp_victim;
  tag_entry_t       fill_entry;

  assign active         = (state == RUN) && !rst;
  assign guard          = (fill_streak == 3'd4);
  assign bus.fill_ready = active && !guard;
  assign bus.lk_ready   = active && (guard || !bus.fill_valid);
  assign fill_gnt       = bus.fill_valid && bus.fill_ready;
  assign lk_gnt         = bus.lk_valid && bus.lk_ready;
  assign fill_entry     = {bus.fill_vld, bus.fill_tag};

  always_comb begin
    sram_csb0    = 1'b1;
    sram_web0_aL = 1'b1;
    sram_wmask0  = '0;
    sram_addr0   = '0;
    sram_din0    = '0;
    if (state == INIT) begin
      sram_csb0    = 1'b0;
      sram_web0_aL = 1'b0;
      sram_wmask0  = '1;
      sram_addr0   = init_cnt;
    end else if (fill_gnt) begin
      sram_csb0    = 1'b0;
      sram_web0_aL = 1'b0;
      sram_wmask0  = bus.fill_way ? 2'b10 : 2'b01;
      sram_addr0   = bus.fill_idx;
      sram_din0    = bus.fill_way ? {fill_entry, {WAY_W{1'b0}}} : {{WAY_W{1'b0}}, fill_entry};
    end else if (lk_gnt) begin
      sram_csb0  = 1'b0;
      sram_addr0 = bus.lk_idx;
    end
  end

  tag_cmp_2way u_cmp (
    .dout   (sram_dout0),
    .tag    (pend_tag),
    .rr_bit (pend_rr),
    .hit    (cmp_hit),
    .way    (cmp_way),
    .victim (cmp_victim)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= INIT;
      init_cnt       <= '0;
      init_done      <= 1'b0;
      rr_bits        <= '0;
      fill_streak    <= '0;
      pend_vld       <= 1'b0;
      pend_tag       <= '0;
      pend_rr        <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_hit    <= 1'b0;
      bus.rsp_way    <= 1'b0;
      bus.rsp_victim <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == IDX_W'(SETS - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN:     ;
        default: state <= INIT;
      endcase

      if (fill_gnt) rr_bits[bus.fill_idx] <= ~bus.fill_way;
      // Streak only grows while a lookup is actually waiting behind the fills.
      fill_streak <= (fill_gnt && bus.lk_valid) ? fill_streak + 3'd1 : 3'd0;

      pend_vld <= lk_gnt;
      if (lk_gnt) begin
        pend_tag <= bus.lk_tag;
        pend_rr  <= rr_bits[bus.lk_idx];
      end

      // sram_dout0 is only trusted at the edge right after a lookup grant.
      bus.rsp_valid  <= pend_vld;
      bus.rsp_hit    <= pend_vld && cmp_hit;
      bus.rsp_way    <= pend_vld && cmp_way;
      bus.rsp_victim <= pend_vld && cmp_victim;
    end
  end
endmodule

// File: tb/tb_tag_array_ctrl.sv
// Directed scoreboard bench for tag_array_ctrl with a behavioural 1RW SRAM (registered inputs, delayed read data).
module tb_tag_array_ctrl;
  import tag_array_pkg::*;

  localparam int DELAY  = 3;
  localparam int T_HOLD = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tag_array_ctrl_if bus ();

  logic        init_done;
  logic        csb0, web0;
  logic [1:0]  wmask0;
  logic [5:0]  addr0;
  logic [47:0] din0;
  logic [47:0] dout0;

  tag_array_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .init_done    (init_done),
    .sram_csb0    (csb0),
    .sram_web0_aL (web0),
    .sram_wmask0  (wmask0),
    .sram_addr0   (addr0),
    .sram_din0    (din0),
    .sram_dout0   (dout0)
  );

  // SRAM model: inputs registered at posedge, access at negedge, read data held until T_HOLD after next posedge.
  logic [47:0] mem [64];
  logic        csb_r = 1'b1, web_r = 1'b1;
  logic [1:0]  wmask_r = '0;
  logic [5:0]  addr_r = '0;
  logic [47:0] din_r = '0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '1;
    dout0 = 'x;
  end

  always @(posedge clk) begin
    csb_r   <= csb0;
    web_r   <= web0;
    wmask_r <= wmask0;
    addr_r  <= addr0;
    din_r   <= din0;
  end

  always @(posedge clk) begin
    #T_HOLD;
    dout0 = 'x;
  end

  always @(negedge clk) begin
    if (!csb_r && !web_r) begin
      if (wmask_r[0]) mem[addr_r][23:0]  = din_r[23:0];
      if (wmask_r[1]) mem[addr_r][47:24] = din_r[47:24];
    end
  end

  always @(negedge clk) begin
    if (!csb_r && web_r) begin
      #DELAY;
      dout0 = mem[addr_r];
    end
  end

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  r;
    int unsigned cyc;
  } exp_t;

  exp_t        sbq[$];
  int          hist[$];
  logic [2:0]  last_rsp = '1;
  int unsigned cyc = 0;

  logic        ref_v  [64][2];
  logic [22:0] ref_t  [64][2];
  logic        ref_rr [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference cache model and scoreboard, evaluated mid-cycle when handshakes are stable.
  always @(negedge clk) begin
    exp_t e;
    int   g;
    logic h0, h1, vic;
    if (rst) begin
      sbq.delete();
      for (int s = 0; s < 64; s++) begin
        ref_v[s][0] = 1'b0;
        ref_v[s][1] = 1'b0;
        ref_rr[s]   = 1'b0;
      end
    end else begin
      if (bus.rsp_valid) begin
        last_rsp = {bus.rsp_hit, bus.rsp_way, bus.rsp_victim};
        if (sbq.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          check("rsp_cycle", cyc, e.cyc + 2);
          check("rsp_fields", last_rsp, e.r);
        end
      end
      g = 0;
      if (bus.fill_valid && bus.fill_ready) begin
        g = 1;
        ref_v[bus.fill_idx][bus.fill_way] = bus.fill_vld;
        ref_t[bus.fill_idx][bus.fill_way] = bus.fill_tag;
        ref_rr[bus.fill_idx]              = ~bus.fill_way;
      end
      if (bus.lk_valid && bus.lk_ready) begin
        if (g == 1) check("dual_grant", 1, 0);
        g   = 2;
        h0  = ref_v[bus.lk_idx][0] && (ref_t[bus.lk_idx][0] == bus.lk_tag);
        h1  = ref_v[bus.lk_idx][1] && (ref_t[bus.lk_idx][1] == bus.lk_tag);
        vic = !ref_v[bus.lk_idx][0] ? 1'b0 : (!ref_v[bus.lk_idx][1] ? 1'b1 : ref_rr[bus.lk_idx]);
        e.r   = {h0 || h1, !h0 && h1, vic};
        e.cyc = cyc;
        sbq.push_back(e);
      end
      hist.push_back(g);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [5:0] idx, input logic w, input logic [22:0] t, input logic v);
    bit          acc;
    int unsigned n = 0;
    bus.fill_idx   = idx;
    bus.fill_way   = w;
    bus.fill_tag   = t;
    bus.fill_vld   = v;
    bus.fill_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.fill_ready;
      step();
      n++;
    end while (!acc && n < 20);
    bus.fill_valid = 1'b0;
    check("fill_accept", acc, 1);
  endtask

  task automatic do_lookup(input logic [5:0] idx, input logic [22:0] t);
    bit          acc;
    int unsigned n = 0;
    bus.lk_idx   = idx;
    bus.lk_tag   = t;
    bus.lk_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = bus.lk_ready;
      step();
      n++;
    end while (!acc && n < 20);
    bus.lk_valid = 1'b0;
    check("lk_accept", acc, 1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain", sbq.size(), 0);
  endtask

  task automatic wait_init(output int unsigned n);
    n = 0;
    do begin
      step();
      n++;
    end while (!init_done && n < 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned n;
    int          exp4 [10];
    exp4 = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    bus.lk_valid = 0; bus.lk_idx = '0; bus.lk_tag = '0;
    bus.fill_valid = 0; bus.fill_idx = '0; bus.fill_way = 0; bus.fill_tag = '0; bus.fill_vld = 0;

    // Reset and post-reset clear
    step(); step();
    @(negedge clk);
    check("reset_outputs", {init_done, bus.lk_ready, bus.fill_ready, bus.rsp_valid,
                            bus.rsp_hit, bus.rsp_way, bus.rsp_victim}, 7'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_init(n);
    check("init_cycles", n, 64);
    @(negedge clk);
    check("sram_idle", {csb0, web0, wmask0, addr0, din0}, {1'b1, 1'b1, 2'b00, 6'd0, 48'd0});
    #1;
    check("clear_set0", mem[0], 48'h0);
    check("clear_set63", mem[63], 48'h0);
    step();
    do_lookup(6'd0, 23'h0);
    do_lookup(6'd63, 23'h0);
    drain();

    // Fill then hit
    do_fill(6'd5, 1'b1, 23'h12345, 1'b1);
    do_lookup(6'd5, 23'h12345);
    drain();
    check("hit_way1", last_rsp, 3'b110);

    // Victim selection follows the round-robin bit
    do_fill(6'd9, 1'b0, 23'h00aaa, 1'b1);
    do_fill(6'd9, 1'b1, 23'h00bbb, 1'b1);
    do_lookup(6'd9, 23'h00ccc);
    drain();
    check("victim_rr0", last_rsp, 3'b000);
    do_fill(6'd9, 1'b0, 23'h00ddd, 1'b1);
    do_lookup(6'd9, 23'h00ccc);
    drain();
    check("victim_rr1", last_rsp, 3'b001);

    // Starvation guard under sustained contention
    bus.lk_idx = 6'd20; bus.lk_tag = 23'd103; bus.lk_valid = 1'b1;
    bus.fill_idx = 6'd20; bus.fill_vld = 1'b1; bus.fill_valid = 1'b1;
    hist.delete();
    for (int i = 0; i < 10; i++) begin
      bus.fill_way = i[0];
      bus.fill_tag = 23'(100 + i);
      step();
    end
    bus.lk_valid = 1'b0; bus.fill_valid = 1'b0;
    check("guard_len", hist.size(), 10);
    for (int i = 0; i < 10; i++) check($sformatf("guard_grant%0d", i), 64'(hist[i]), 64'(exp4[i]));
    drain();
    check("guard_last_rsp", last_rsp, 3'b001);

    // Invalidate
    do_fill(6'd5, 1'b1, 23'h12345, 1'b0);
    do_lookup(6'd5, 23'h12345);
    drain();
    check("invalidate_miss", last_rsp, 3'b000);

    // Reset with a lookup in flight
    do_lookup(6'd9, 23'h00ddd);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_drops_rsp", bus.rsp_valid, 0);
    wait_init(n);
    check("reinit_cycles", n, 64);
    @(negedge clk); #1;
    check("reclear_set5", mem[5], 48'h0);
    step();
    last_rsp = '1;
    do_lookup(6'd5, 23'h12345);
    drain();
    check("post_reset_miss", last_rsp, 3'b000);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
